// File: rtl/axis_packet_reassembler.sv
// Reassembles FIRST/MIDDLE/LAST/ONLY packets into one AXIS message plus a completion record.
// Define AXIS_REASM_LEN_CHECK_EN to enable PMTU and message-length status checks.
module axis_packet_reassembler #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_pkt_valid,
  output logic                    s_pkt_ready,
  input  logic [1:0]              s_pkt_opcode,
  input  logic [23:0]             s_pkt_loc_qp,
  input  logic [31:0]             s_pkt_dma_length,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_cmp_valid,
  input  logic                    m_cmp_ready,
  output logic [23:0]             m_cmp_loc_qp,
  output logic [31:0]             m_cmp_byte_count,
  output logic [3:0]              m_cmp_status,
  input  logic [2:0]              pmtu
);

  localparam int KW = DATA_WIDTH / 8;
  localparam logic [12:0] BEAT_BYTES = 13'(KW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam logic [1:0] CMPL = 2'd3;

  localparam logic [1:0] OP_FIRST = 2'd0;
  localparam logic [1:0] OP_LAST  = 2'd2;
  localparam logic [1:0] OP_ONLY  = 2'd3;

  logic [1:0]  state;
  logic        msg_open;
  logic        cur_last;
  logic        cmp_pend;
  logic [23:0] qp_q;
  logic [31:0] total_q;
  logic [3:0]  status_q;
  logic [12:0] pkt_cnt;

  logic        op_start;
  logic        start_msg;
  logic        beat_acc;
  logic [12:0] beat_bytes;
  logic [12:0] pkt_sum;
  logic [32:0] tot_ext;
  logic [31:0] tot_sum;
  logic        len_err_pkt;
  logic        len_err_msg;

  function automatic logic [12:0] popcnt(input logic [KW-1:0] k);
    logic [12:0] c;
    c = '0;
    for (int i = 0; i < KW; i++) c = c + 13'(k[i]);
    return c;
  endfunction

  assign op_start  = (s_pkt_opcode == OP_FIRST) || (s_pkt_opcode == OP_ONLY);
  assign start_msg = (state == IDLE) && s_pkt_valid && !msg_open && op_start;

  assign s_pkt_ready   = (state == IDLE) && !rst;
  assign s_axis_tready = ((state == DATA) && (!m_axis_tvalid || m_axis_tready))
                      || (state == DROP);
  assign beat_acc      = (state == DATA) && s_axis_tvalid && s_axis_tready;

  assign beat_bytes = s_axis_tlast ? popcnt(s_axis_tkeep) : BEAT_BYTES;
  assign pkt_sum    = pkt_cnt + beat_bytes;
  assign tot_ext    = {1'b0, total_q} + {20'd0, pkt_sum};
  // Message total saturates instead of wrapping.
  assign tot_sum    = tot_ext[32] ? 32'hFFFF_FFFF : tot_ext[31:0];

`ifdef AXIS_REASM_LEN_CHECK_EN
  logic [31:0] dma_q;
  logic [2:0]  pmtu_q;
  logic [12:0] pmtu_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_q  <= '0;
      pmtu_q <= '0;
    end else if (start_msg) begin
      dma_q  <= s_pkt_dma_length;
      pmtu_q <= pmtu;
    end
  end

  assign pmtu_bytes  = (pmtu_q > 3'd4) ? 13'd4096 : (13'd256 << pmtu_q);
  assign len_err_pkt = cur_last ? ((pkt_sum > pmtu_bytes) || (pkt_sum == '0))
                                : (pkt_sum != pmtu_bytes);
  assign len_err_msg = cur_last && (tot_sum != dma_q);
`else
  logic unused_len;
  assign unused_len  = ^{pmtu, s_pkt_dma_length};
  assign len_err_pkt = 1'b0;
  assign len_err_msg = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      msg_open <= 1'b0;
      cur_last <= 1'b0;
      cmp_pend <= 1'b0;
      qp_q     <= '0;
      total_q  <= '0;
      status_q <= '0;
      pkt_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (s_pkt_valid) begin
          pkt_cnt <= '0;
          if (!msg_open) begin
            qp_q    <= s_pkt_loc_qp;
            total_q <= '0;
            if (op_start) begin
              state    <= DATA;
              msg_open <= 1'b1;
              cur_last <= (s_pkt_opcode == OP_ONLY);
              status_q <= 4'h0;
            end else begin
              // Orphan continuation: drop it, then report a zero-byte sequence error.
              state    <= DROP;
              cmp_pend <= 1'b1;
              status_q <= 4'h8;
            end
          end else if (op_start) begin
            state       <= DROP;
            status_q[3] <= 1'b1;
          end else begin
            state    <= DATA;
            cur_last <= (s_pkt_opcode == OP_LAST);
          end
        end
        DATA: if (beat_acc) begin
          pkt_cnt <= pkt_sum;
          if (s_axis_tlast) begin
            pkt_cnt  <= '0;
            total_q  <= tot_sum;
            status_q <= status_q
                      | {1'b0, len_err_msg, len_err_pkt, s_axis_tuser};
            if (cur_last) begin
              state    <= CMPL;
              msg_open <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: if (s_axis_tvalid && s_axis_tlast) begin
          state <= cmp_pend ? CMPL : IDLE;
        end
        CMPL: if (m_cmp_ready) begin
          state    <= IDLE;
          cmp_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (beat_acc) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tkeep  <= s_axis_tkeep;
      m_axis_tlast  <= s_axis_tlast && cur_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

  assign m_cmp_valid      = (state == CMPL);
  assign m_cmp_loc_qp     = qp_q;
  assign m_cmp_byte_count = total_q;
  assign m_cmp_status     = status_q;

endmodule

// File: tb/tb_axis_packet_reassembler.sv
// Table-driven bench with beat and completion scoreboards for axis_packet_reassembler.
// Expected status bits 1/2 follow AXIS_REASM_LEN_CHECK_EN.
module tb_axis_packet_reassembler;

  localparam int DW = 64;
  localparam int KW = DW / 8;

`ifdef AXIS_REASM_LEN_CHECK_EN
  localparam bit LEN = 1'b1;
`else
  localparam bit LEN = 1'b0;
`endif

  localparam logic [1:0] OP_FIRST  = 2'd0;
  localparam logic [1:0] OP_MIDDLE = 2'd1;
  localparam logic [1:0] OP_LAST   = 2'd2;
  localparam logic [1:0] OP_ONLY   = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_pkt_valid = 1'b0;
  logic          s_pkt_ready;
  logic [1:0]    s_pkt_opcode = '0;
  logic [23:0]   s_pkt_loc_qp = '0;
  logic [31:0]   s_pkt_dma_length = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          m_cmp_valid;
  logic          m_cmp_ready = 1'b1;
  logic [23:0]   m_cmp_loc_qp;
  logic [31:0]   m_cmp_byte_count;
  logic [3:0]    m_cmp_status;
  logic [2:0]    pmtu = '0;

  always #5 clk = ~clk;

  axis_packet_reassembler #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_pkt_valid(s_pkt_valid), .s_pkt_ready(s_pkt_ready),
    .s_pkt_opcode(s_pkt_opcode), .s_pkt_loc_qp(s_pkt_loc_qp),
    .s_pkt_dma_length(s_pkt_dma_length),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_cmp_valid(m_cmp_valid), .m_cmp_ready(m_cmp_ready),
    .m_cmp_loc_qp(m_cmp_loc_qp), .m_cmp_byte_count(m_cmp_byte_count),
    .m_cmp_status(m_cmp_status), .pmtu(pmtu)
  );

  typedef struct {
    logic [1:0]  op;
    logic [23:0] qp;
    logic [31:0] dma;
    logic [2:0]  pm;
    int          bytes;
    logic        user;
    logic        fwd;
    logic        cmp;
    logic [31:0] bc;
    logic [3:0]  st;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct {
    logic [23:0] qp;
    logic [31:0] bc;
    logic [3:0]  st;
  } cmp_t;

  beat_t exp_q[$];
  cmp_t  cmp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    rdy_mode = 0;
  vec_t  tbl[12];

  task automatic check(string name, logic [191:0] act, logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name, int a, int b);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0d, want %0d", name, a, b);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
    m_cmp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    beat_t e;
    cmp_t  c;
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("m_axis_tdata", m_axis_tdata, e.d);
          check("m_axis_tkeep", m_axis_tkeep, e.k);
          check("m_axis_tlast", m_axis_tlast, e.l);
        end
      end
      if (m_cmp_valid && m_cmp_ready) begin
        if (cmp_q.size() == 0) fail_now("unexpected_cmp", 1, 0);
        else begin
          c = cmp_q.pop_front();
          check("m_cmp_loc_qp", m_cmp_loc_qp, c.qp);
          check("m_cmp_byte_count", m_cmp_byte_count, c.bc);
          check("m_cmp_status", m_cmp_status, c.st);
        end
      end
    end
  end

  task automatic send_meta(logic [1:0] op, logic [23:0] qp,
                           logic [31:0] dma, logic [2:0] pm);
    int n;
    s_pkt_valid      = 1'b1;
    s_pkt_opcode     = op;
    s_pkt_loc_qp     = qp;
    s_pkt_dma_length = dma;
    pmtu             = pm;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_pkt_ready && n < 2000);
    if (!s_pkt_ready) fail_now("meta_timeout", n, 2000);
    @(posedge clk);
    #1;
    s_pkt_valid = 1'b0;
  endtask

  task automatic send_beat(logic [DW-1:0] d, logic [KW-1:0] k,
                           logic l, logic u);
    int n;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_tready && n < 2000);
    if (!s_axis_tready) fail_now("beat_timeout", n, 2000);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic send_pkt(vec_t v, int row);
    int nb;
    int rem;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
    logic l;
    cmp_t c;
    beat_t e;
    nb = (v.bytes + 7) / 8;
    rem = v.bytes - 8 * (nb - 1);
    if (v.cmp) begin
      c.qp = v.qp;
      c.bc = v.bc;
      c.st = v.st;
      cmp_q.push_back(c);
    end
    send_meta(v.op, v.qp, v.dma, v.pm);
    for (int b = 0; b < nb; b++) begin
      l = (b == nb - 1);
      k = l ? KW'((1 << rem) - 1) : {KW{1'b1}};
      d = {32'(row), 32'(b)};
      if (v.fwd) begin
        e.d = d;
        e.k = k;
        e.l = l && (v.op == OP_LAST || v.op == OP_ONLY);
        exp_q.push_back(e);
      end
      send_beat(d, k, l, l ? v.user : 1'b0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || cmp_q.size() != 0)
      fail_now("drain_timeout", exp_q.size() + cmp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t e;
    vec_t  v;
    tbl[0]  = '{OP_ONLY,   24'd1,  32'd100, 3'd0, 100, 1'b0, 1'b1, 1'b1, 32'd100, 4'h0};
    tbl[1]  = '{OP_FIRST,  24'd2,  32'd600, 3'd0, 256, 1'b0, 1'b1, 1'b0, 32'd0,   4'h0};
    tbl[2]  = '{OP_MIDDLE, 24'd2,  32'd0,   3'd0, 256, 1'b0, 1'b1, 1'b0, 32'd0,   4'h0};
    tbl[3]  = '{OP_LAST,   24'd2,  32'd0,   3'd0, 88,  1'b0, 1'b1, 1'b1, 32'd600, 4'h0};
    tbl[4]  = '{OP_MIDDLE, 24'd3,  32'd0,   3'd0, 32,  1'b0, 1'b0, 1'b1, 32'd0,   4'h8};
    tbl[5]  = '{OP_FIRST,  24'd4,  32'd456, 3'd0, 200, 1'b0, 1'b1, 1'b0, 32'd0,   4'h0};
    tbl[6]  = '{OP_LAST,   24'd4,  32'd0,   3'd0, 256, 1'b0, 1'b1, 1'b1, 32'd456,
                LEN ? 4'h2 : 4'h0};
    tbl[7]  = '{OP_ONLY,   24'd11, 32'd300, 3'd0, 300, 1'b0, 1'b1, 1'b1, 32'd300,
                LEN ? 4'h2 : 4'h0};
    tbl[8]  = '{OP_ONLY,   24'd12, 32'd50,  3'd7, 64,  1'b0, 1'b1, 1'b1, 32'd64,
                LEN ? 4'h4 : 4'h0};
    tbl[9]  = '{OP_FIRST,  24'd6,  32'd512, 3'd0, 256, 1'b0, 1'b1, 1'b0, 32'd0,   4'h0};
    tbl[10] = '{OP_FIRST,  24'd7,  32'd64,  3'd0, 64,  1'b0, 1'b0, 1'b0, 32'd0,   4'h0};
    tbl[11] = '{OP_LAST,   24'd6,  32'd0,   3'd0, 256, 1'b0, 1'b1, 1'b1, 32'd512, 4'h8};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {s_pkt_ready, s_axis_tready, m_axis_tvalid, m_axis_tlast,
           m_cmp_valid, m_cmp_loc_qp, m_cmp_byte_count, m_cmp_status,
           m_axis_tdata, m_axis_tkeep}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", s_pkt_ready, 1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      rdy_mode = (i < 4) ? 0 : 2;
      send_pkt(tbl[i], i);
    end
    wait_drain();

    rdy_mode = 1;
    v = '{OP_FIRST, 24'd8, 32'd296, 3'd0, 256, 1'b0, 1'b1, 1'b0, 32'd0, 4'h0};
    send_pkt(v, 20);
    v = '{OP_LAST, 24'd8, 32'd0, 3'd0, 40, 1'b1, 1'b1, 1'b1, 32'd296, 4'h1};
    send_pkt(v, 21);
    wait_drain();

    send_meta(OP_FIRST, 24'd9, 32'd512, 3'd0);
    for (int b = 0; b < 3; b++) begin
      e.d = {32'd22, 32'(b)};
      e.k = {KW{1'b1}};
      e.l = 1'b0;
      exp_q.push_back(e);
      send_beat(e.d, e.k, 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs",
          {s_pkt_ready, s_axis_tready, m_axis_tvalid, m_axis_tlast,
           m_cmp_valid, m_cmp_loc_qp, m_cmp_byte_count, m_cmp_status,
           m_axis_tdata, m_axis_tkeep}, '0);
    exp_q.delete();
    cmp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_mid_reset", s_pkt_ready, 1'b1);
    @(posedge clk);
    #1;

    rdy_mode = 2;
    v = '{OP_ONLY, 24'd10, 32'd16, 3'd0, 16, 1'b0, 1'b1, 1'b1, 32'd16, 4'h0};
    send_pkt(v, 23);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_reassembler.md
AXIS_PACKET_REASSEMBLER -- requirements
Module: axis_packet_reassembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload width in bits (multiple of 64).
REQ-002 SHALL have clk  in  1  sole clock.
REQ-003 SHALL have rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have s_pkt_valid  in  1  per-packet metadata valid.
REQ-005 SHALL have s_pkt_ready  out  1  metadata accept.
REQ-006 SHALL have s_pkt_opcode  in  2  0=FIRST, 1=MIDDLE, 2=LAST, 3=ONLY.
REQ-007 SHALL have s_pkt_loc_qp  in  24  local QP of packet.
REQ-008 SHALL have s_pkt_dma_length  in  32  expected message bytes, meaningful on FIRST/ONLY.
REQ-009 SHALL have s_axis_tdata  in  DATA_WIDTH  packet payload.
REQ-010 SHALL have s_axis_tkeep  in  DATA_WIDTH/8  byte enables, contiguous from bit 0.
REQ-011 SHALL have s_axis_tvalid / s_axis_tready  in / out  1 each  payload handshake.
REQ-012 SHALL have s_axis_tlast  in  1  last beat of packet.
REQ-013 SHALL have s_axis_tuser  in  1  packet bad-frame flag, sampled on tlast beat.
REQ-014 SHALL have m_axis_tdata / m_axis_tkeep  out  DATA_WIDTH / DATA_WIDTH/8  reassembled message.
REQ-015 SHALL have m_axis_tvalid / m_axis_tready  out / in  1 each  output handshake.
REQ-016 SHALL have m_axis_tlast  out  1  last beat of message.
REQ-017 SHALL have m_cmp_valid / m_cmp_ready  out / in  1 each  completion handshake.
REQ-018 SHALL have m_cmp_loc_qp  out  24  QP of completed message.
REQ-019 SHALL have m_cmp_byte_count  out  32  bytes forwarded for message.
REQ-020 SHALL have m_cmp_status  out  4  bit0 bad frame, bit1 PMTU violation, bit2 length mismatch, bit3 sequence error.
REQ-021 SHALL have pmtu  in  3  0..4 -> 256<<pmtu bytes; 5..7 -> 4096.

Function
REQ-022 SHALL implement states IDLE, DATA, DROP, CMPL; metadata accepted only in IDLE with s_pkt_ready=1, payload only in DATA/DROP.
REQ-023 SHALL in IDLE with no open message: FIRST/ONLY -> DATA, latch qp, dma_length, pmtu, clear total/status; MIDDLE/LAST -> DROP, set pending sequence-error completion (byte_count 0).
REQ-024 SHALL in IDLE with open message: MIDDLE/LAST -> DATA; FIRST/ONLY -> DROP, set status bit3 of open message, message stays open.
REQ-025 SHALL in DROP consume payload with s_axis_tready=1, emit nothing, exit on tlast to CMPL if completion pending else IDLE.
REQ-026 SHALL forward DATA beats through one register slice: latency 1 cycle, s_axis_tready = slice empty or m_axis_tready, no bubbles.
REQ-027 SHALL drive m_axis_tlast only on tlast beat of LAST/ONLY packet; FIRST/MIDDLE boundaries invisible on output.
REQ-028 SHALL count packet bytes as DATA_WIDTH/8 per non-tlast beat plus popcount(tkeep) on tlast beat (13-bit), accumulate into 32-bit total, saturating at 2^32-1.
REQ-029 SHALL set bit1 if FIRST/MIDDLE packet bytes != PMTU or LAST/ONLY bytes > PMTU or = 0.
REQ-030 SHALL set bit2 if message total != latched dma_length at message end; OR s_axis_tuser into bit0 per packet.
REQ-031 SHALL enter CMPL after tlast of LAST/ONLY is accepted; hold m_cmp_* stable with m_cmp_valid=1 until m_cmp_ready, then IDLE; s_pkt_ready=0 in CMPL.
REQ-032 SHALL allow m_cmp_valid assertion while last data beat still in output slice (no ordering between interfaces).

Reset
REQ-033 SHALL on rst asynchronously force IDLE, no open message, counters/status 0, s_pkt_ready, s_axis_tready, m_axis_tvalid, m_axis_tlast, m_cmp_valid 0, m_cmp_* data 0.
REQ-034 SHALL discard any partial message on reset mid-operation; s_pkt_ready=1 first cycle after rst deasserts.

Configuration
REQ-035 SHALL with AXIS_REASM_LEN_CHECK_EN defined perform REQ-029/REQ-030 length checks; undefined, status bits 1 and 2 are constant 0 and byte counting still drives m_cmp_byte_count.

Verification
REQ-036 SHALL test ONLY, pmtu=0, dma_length=100, 13 beats last tkeep=0x0F -> one 13-beat message, tlast on beat 13, cmp byte_count=100, status=0.
REQ-037 SHALL test FIRST(256B)+MIDDLE(256B)+LAST(88B), pmtu=0, dma_length=600 -> 75 contiguous beats, single tlast, byte_count=600, status=0.
REQ-038 SHALL test MIDDLE in IDLE with 4 beats -> no m_axis output, cmp byte_count=0, status=0x8.
REQ-039 SHALL test FIRST of 200B with pmtu=0, dma_length=456, then LAST 256B -> status=0x2 defined, 0x0 undefined; byte_count=456.
REQ-040 SHALL test LAST packet tuser=1, m_axis_tready toggling 50%, rst asserted mid-DATA on a second message -> first cmp status bit0=1, all outputs 0 during reset.
